flag_alu: RTL

FLAG_ALU -- requirements
Module: flag_alu

---
 rtl/alu_pkg.sv | 30 +++
 rtl/flag_alu_if.sv | 36 +++
 rtl/shift_add_mul.sv | 84 ++++++++
 rtl/flag_alu.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the flag-setting ALU: default operand width, opcode
// encoding and the controller state encoding.
// -----------------------------------------------------------------------------
package alu_pkg;

    // Default operand/result width in bits.
    localparam int ALU_WIDTH = 32;

    // Opcode encoding as seen on the op input.
    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_MUL = 3'b101,
        OP_CMP = 3'b110,
        OP_MOV = 3'b111
    } op_e;

    // Controller states.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MULT = 2'b01,
        S_DONE = 2'b10
    } state_e;

endpackage : alu_pkg

// File: rtl/flag_alu_if.sv
// -----------------------------------------------------------------------------
// flag_alu_if
// Request/response bundle of the flag-setting ALU.
//   master : drives start, op, setflags, a, b; observes the results
//   slave  : the ALU; drives result, done, busy, z, v, n, flagwe
// -----------------------------------------------------------------------------
interface flag_alu_if
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) ();

    logic             start;
    logic [2:0]       op;
    logic             setflags;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             done;
    logic             busy;
    logic             z;
    logic             v;
    logic             n;
    logic             flagwe;

    modport master (
        output start, op, setflags, a, b,
        input  result, done, busy, z, v, n, flagwe
    );

    modport slave (
        input  start, op, setflags, a, b,
        output result, done, busy, z, v, n, flagwe
    );

endinterface : flag_alu_if

// File: rtl/shift_add_mul.sv
// -----------------------------------------------------------------------------
// shift_add_mul
// Iterative unsigned multiplier, one multiplier bit per cycle, returning the
// low WIDTH bits of a*b.
//   clk, rst : clock, asynchronous active-high reset
//   start    : load a/b and begin (operands are captured on this edge)
//   a, b     : multiplicand, multiplier
//   product  : low WIDTH bits of the product, valid while ready is high
//   ready    : high during the last iteration cycle; product already includes
//              the final partial product, so the caller can latch it on the
//              same edge that retires the last bit
// -----------------------------------------------------------------------------
module shift_add_mul
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] product,
    output logic             ready
);

    localparam int             CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] mcand_q,  mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q,    acc_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             run_q,    run_d;
    logic [WIDTH-1:0] acc_next;

    // Accumulator after adding this cycle's partial product.
    assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign product  = acc_next;
    assign ready    = run_q && (cnt_q == LAST);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        if (start) begin
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
            run_d    = 1'b1;
        end else if (run_q) begin
            acc_d    = acc_next;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == LAST) begin
                run_d = 1'b0;
                cnt_d = '0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
        end
    end

endmodule : shift_add_mul

// File: rtl/flag_alu.sv
// -----------------------------------------------------------------------------
// flag_alu
// Multi-cycle ALU with optional condition-flag update (ADD, SUB, AND, OR, XOR,
// MUL, CMP, MOV). Single-cycle ops complete one cycle after acceptance; MUL
// runs through the iterative multiplier and completes WIDTH+1 cycles after.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : flag_alu_if slave -- start/op/setflags/a/b in,
//              result/done/busy/z/v/n/flagwe out
// -----------------------------------------------------------------------------
module flag_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input logic       clk,
    input logic       rst,
    flag_alu_if.slave bus
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             z_q, z_d;
    logic             v_q, v_d;
    logic             n_q, n_d;
    logic             flagwe_q, flagwe_d;
    logic             setflags_q, setflags_d;

    op_e              op_in;
    logic [WIDTH-1:0] sum, diff, alu_val;
    logic             alu_v, alu_upd;

    logic             mul_start;
    logic             mul_ready;
    logic [WIDTH-1:0] mul_product;

    assign op_in = op_e'(bus.op);

    // Both adders work on the live operands: single-cycle ops retire on the
    // acceptance edge, so their inputs are consumed exactly when latched.
    assign sum  = bus.a + bus.b;
    assign diff = bus.a + ~bus.b + ONE;

    // Single-cycle datapath: value, overflow, and whether flags get updated.
    always_comb begin
        alu_val = '0;
        alu_v   = 1'b0;
        alu_upd = bus.setflags || (op_in == OP_CMP);
        case (op_in)
            OP_ADD: begin
                alu_val = sum;
                alu_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                          (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB, OP_CMP: begin
                alu_val = diff;
                alu_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                          (diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_AND:  alu_val = bus.a & bus.b;
            OP_OR:   alu_val = bus.a | bus.b;
            OP_XOR:  alu_val = bus.a ^ bus.b;
            OP_MOV:  alu_val = bus.b;
            OP_MUL:  alu_val = '0;
            default: alu_val = '0;
        endcase
    end

    // Next-state and register-update logic.
    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        z_d        = z_q;
        v_d        = v_q;
        n_d        = n_q;
        flagwe_d   = 1'b0;
        setflags_d = setflags_q;
        mul_start  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    setflags_d = bus.setflags;
                    if (op_in == OP_MUL) begin
                        mul_start = 1'b1;
                        state_d   = S_MULT;
                    end else begin
                        state_d = S_DONE;
                        // CMP only sets flags; the difference is discarded.
                        if (op_in != OP_CMP) begin
                            result_d = alu_val;
                        end
                        if (alu_upd) begin
                            z_d      = (alu_val == '0);
                            n_d      = alu_val[WIDTH-1];
                            v_d      = alu_v;
                            flagwe_d = 1'b1;
                        end
                    end
                end
            end
            S_MULT: begin
                if (mul_ready) begin
                    state_d  = S_DONE;
                    result_d = mul_product;
                    if (setflags_q) begin
                        z_d      = (mul_product == '0);
                        n_d      = mul_product[WIDTH-1];
                        v_d      = 1'b0;
                        flagwe_d = 1'b1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            result_q   <= '0;
            z_q        <= 1'b0;
            v_q        <= 1'b0;
            n_q        <= 1'b0;
            flagwe_q   <= 1'b0;
            setflags_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            result_q   <= result_d;
            z_q        <= z_d;
            v_q        <= v_d;
            n_q        <= n_d;
            flagwe_q   <= flagwe_d;
            setflags_q <= setflags_d;
        end
    end

    shift_add_mul #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk    (clk),
        .rst    (rst),
        .start  (mul_start),
        .a      (bus.a),
        .b      (bus.b),
        .product(mul_product),
        .ready  (mul_ready)
    );

    assign bus.result = result_q;
    assign bus.z      = z_q;
    assign bus.v      = v_q;
    assign bus.n      = n_q;
    assign bus.flagwe = flagwe_q;
    assign bus.done   = (state_q == S_DONE);
    assign bus.busy   = (state_q != S_IDLE);

endmodule : flag_alu
